lva_access_ctrl: RTL and testbench

- Initiator side of the local-variable-array (LVA) memory handshake.
- Accepts load, store and increment commands from the execute stage, with a frame base and a slot index.
- Drives the LVA trigger/write/addr/writevalue signals and waits for the LVA done pulse.
- Returns the resulting value, or an error, to the execute stage as a one-cycle response.

---
 rtl/lva_pkg.sv | 36 +++
 rtl/lva_access_ctrl_if.sv | 46 ++++
 rtl/lva_addr_check.sv | 26 ++
 rtl/lva_access_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lva_access_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lva_pkg.sv
// rtl/lva_pkg.sv - shared types and op encodings for the LVA access controller
//
// Purpose : op encoding constants (shared with the execute-stage decoder),
//           the op and FSM state enums, and a sign-extension helper.
// Ports   : none (package).

package lva_pkg;

  // Op encodings on cmd_op; the decoder uses the same constants.
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    LOAD  = OP_LOAD,
    STORE = OP_STORE,
    INC   = OP_INC,
    RSVD  = OP_RSVD
  } lva_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RESP
  } lva_state_t;

  // Sign-extend the 8-bit INC constant to a full LVA word.
  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

endpackage

// File: rtl/lva_access_ctrl_if.sv
// rtl/lva_access_ctrl_if.sv - command/response and LVA handshake bundle
//
// Purpose : groups the execute-stage command/response signals and the LVA
//           request/completion signals of one access controller.
// Modports: master - the access controller (accepts commands, drives the LVA)
//           slave  - its environment (execute stage plus LVA instance)
// Params  : ADDR - LVA address width.

interface lva_access_ctrl_if #(
  parameter int ADDR = 10
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [7:0]      cmd_index;
  logic [31:0]     cmd_value;
  logic [7:0]      cmd_const;
  logic [ADDR-1:0] frame_base;

  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;

  logic            lva_trigger;
  logic            lva_write;
  logic [ADDR-1:0] lva_addr;
  logic [31:0]     lva_writevalue;
  logic [31:0]     lva_readvalue;
  logic            lva_done;

  modport master (
    input  cmd_valid, cmd_op, cmd_index, cmd_value, cmd_const, frame_base,
    input  lva_readvalue, lva_done,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output lva_trigger, lva_write, lva_addr, lva_writevalue
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_index, cmd_value, cmd_const, frame_base,
    output lva_readvalue, lva_done,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  lva_trigger, lva_write, lva_addr, lva_writevalue
  );

endinterface

// File: rtl/lva_addr_check.sv
// rtl/lva_addr_check.sv - effective slot address and bounds flag
//
// Purpose : eff = frame_base + index, one bit wider than the LVA address so
//           the carry is never lost; flags eff beyond the LVA.
// Ports   : frame_base   in  ADDR    frame base slot
//           index        in  8       slot index (unsigned)
//           eff          out ADDR+1  effective slot number
//           out_of_range out 1       eff >= LVA_SIZE
// Params  : LVA_SIZE - number of LVA words.

module lva_addr_check #(
  parameter  int LVA_SIZE = 1024,
  localparam int ADDR     = $clog2(LVA_SIZE)
) (
  input  logic [ADDR-1:0] frame_base,
  input  logic [7:0]      index,
  output logic [ADDR:0]   eff,
  output logic            out_of_range
);

  always_comb begin
    eff          = {1'b0, frame_base} + (ADDR+1)'(index);
    out_of_range = (eff >= (ADDR+1)'(LVA_SIZE));
  end

endmodule

// File: rtl/lva_access_ctrl.sv
// rtl/lva_access_ctrl.sv - LVA load/store/increment initiator
//
// Purpose : accepts one command at a time from the execute stage, performs
//           the LVA read and/or write it needs, and returns a one-cycle
//           response (value or error).
// Ports   : clk   in  clock, rising edge
//           rst_n in  asynchronous active-low reset
//           bus   lva_access_ctrl_if.master: cmd_* / frame_base in,
//                 cmd_ready / rsp_* out, lva_* request out, lva_done and
//                 lva_readvalue in
// Params  : LVA_SIZE - LVA depth in 32-bit words
//           TIMEOUT  - done wait limit in cycles (only with LVA_TIMEOUT_EN)
// Config  : `define LVA_TIMEOUT_EN adds the done-wait timeout; without it the
//           controller waits for lva_done indefinitely.

module lva_access_ctrl
  import lva_pkg::*;
#(
  parameter int LVA_SIZE = 1024
`ifdef LVA_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  lva_access_ctrl_if.master   bus
);

  localparam int ADDR = $clog2(LVA_SIZE);

  lva_state_t      state_q, state_d;
  lva_op_t         op_q;
  logic [7:0]      const_q;
  logic [ADDR-1:0] addr_q;
  logic [31:0]     wval_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;

  logic [ADDR:0]   eff;
  logic            out_of_range;
  logic            cmd_err;
  logic            accept;
  logic            timeout_hit;

  // Combinational outputs of the next-state process.
  logic            cmd_ready_c;
  logic            trigger_c;
  logic            write_c;
  logic            rsp_valid_c;
  logic            rsp_set;
  logic [31:0]     rsp_data_d;
  logic            rsp_err_d;
  logic            wval_load;
  logic [31:0]     wval_d;

  lva_addr_check #(.LVA_SIZE(LVA_SIZE)) u_addr_check (
    .frame_base   (bus.frame_base),
    .index        (bus.cmd_index),
    .eff          (eff),
    .out_of_range (out_of_range)
  );

  // eff[ADDR] set already implies out_of_range; it is or-ed in so the carry
  // bit of the sum is consumed explicitly.
  assign cmd_err = out_of_range | eff[ADDR] | (lva_op_t'(bus.cmd_op) == RSVD);
  assign accept  = (state_q == IDLE) && bus.cmd_valid;

`ifdef LVA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q;

  // Cleared in the request cycle, so it reads 0 on the first wait cycle and
  // TIMEOUT-1 on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == RD_REQ || state_q == WR_REQ) begin
      wait_cnt_q <= '0;
    end else if (state_q == RD_WAIT || state_q == WR_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    trigger_c   = 1'b0;
    write_c     = 1'b0;
    rsp_valid_c = 1'b0;
    rsp_set     = 1'b0;
    rsp_data_d  = 32'd0;
    rsp_err_d   = 1'b0;
    wval_load   = 1'b0;
    wval_d      = wval_q;

    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          if (cmd_err) begin
            state_d   = RESP;
            rsp_set   = 1'b1;
            rsp_err_d = 1'b1;
          end else if (lva_op_t'(bus.cmd_op) == STORE) begin
            state_d = WR_REQ;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        trigger_c = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.lva_done) begin
          if (op_q == INC) begin
            wval_load = 1'b1;
            wval_d    = bus.lva_readvalue + sext8(const_q);
            state_d   = WR_REQ;
          end else begin
            rsp_set    = 1'b1;
            rsp_data_d = bus.lva_readvalue;
            state_d    = RESP;
          end
        end else if (timeout_hit) begin
          rsp_set   = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      WR_REQ: begin
        trigger_c = 1'b1;
        write_c   = 1'b1;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        write_c = 1'b1;
        if (bus.lva_done) begin
          rsp_set    = 1'b1;
          rsp_data_d = wval_q;
          state_d    = RESP;
        end else if (timeout_hit) begin
          rsp_set   = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch and response registers. The response registers load only
  // on entry to RESP so rsp_data/rsp_err hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= LOAD;
      const_q    <= '0;
      addr_q     <= '0;
      wval_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= lva_op_t'(bus.cmd_op);
        const_q <= bus.cmd_const;
        if (!cmd_err) begin
          addr_q <= eff[ADDR-1:0];
        end
        if (lva_op_t'(bus.cmd_op) == STORE) begin
          wval_q <= bus.cmd_value;
        end
      end
      if (wval_load) begin
        wval_q <= wval_d;
      end
      if (rsp_set) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign bus.cmd_ready      = cmd_ready_c;
  assign bus.rsp_valid      = rsp_valid_c;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.lva_trigger    = trigger_c;
  assign bus.lva_write      = write_c;
  assign bus.lva_addr       = addr_q;
  assign bus.lva_writevalue = wval_q;

endmodule

// File: tb/tb_lva_access_ctrl.sv
// tb/tb_lva_access_ctrl.sv - self-checking bench for lva_access_ctrl

module tb_lva_access_ctrl;

  localparam int LVA_SIZE = 1024;
  localparam int ADDR     = 10;
  localparam int LVA_D    = 3;    // LVA done latency after trigger
  localparam int TMO      = 64;

  logic clk;
  logic rst_n;

  lva_access_ctrl_if #(.ADDR(ADDR)) bus ();

  lva_access_ctrl #(.LVA_SIZE(LVA_SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference view of LVA contents, updated from the command rules.
  logic [31:0] ref_mem [LVA_SIZE];

  // Environment controls (written only by the main process).
  bit mute = 1'b0;
  int stray_cnt = 0;

  function automatic logic [31:0] seed_word(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h1234_5678;
  endfunction

  // LVA model: done LVA_D cycles after the trigger, memory access at done.
  initial begin : lva_model
    logic [31:0] mem [LVA_SIZE];
    int cnt;
    int stray_served;
    logic p_write;
    logic [ADDR-1:0] p_addr;
    logic [31:0] p_wdata;
    cnt = 0;
    stray_served = 0;
    p_write = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    for (int i = 0; i < LVA_SIZE; i++) mem[i] = seed_word(i);
    bus.lva_done = 1'b0;
    bus.lva_readvalue = 32'd0;
    forever begin
      @(negedge clk);
      bus.lva_done = 1'b0;
      if (stray_cnt != stray_served) begin
        stray_served = stray_cnt;
        bus.lva_done = 1'b1;
        bus.lva_readvalue = $urandom;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.lva_done = 1'b1;
          if (p_write) mem[p_addr] = p_wdata;
          else bus.lva_readvalue = mem[p_addr];
        end
      end
      if (mute) cnt = 0;
      else if (bus.lva_trigger) begin
        cnt = LVA_D;
        p_write = bus.lva_write;
        p_addr = bus.lva_addr;
        p_wdata = bus.lva_writevalue;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_trigger"}, 32'(bus.lva_trigger), 32'd0);
    check({tag, "_write"}, 32'(bus.lva_write), 32'd0);
    check({tag, "_addr"}, 32'(bus.lva_addr), 32'd0);
    check({tag, "_wval"}, bus.lva_writevalue, 32'd0);
  endtask

  // Issue one command, predict its response from the rules, compare.
  task automatic run_cmd(input logic [1:0] op, input logic [ADDR-1:0] base,
                         input logic [7:0] idx, input logic [31:0] val,
                         input logic [7:0] cst, input bit tmo,
                         output logic [31:0] got_data);
    logic [ADDR:0] eff;
    logic [31:0] exp_data;
    logic exp_err, got_err, addr_ok, write_ok;
    int exp_lat, exp_trig, got_lat, trig_seen;
    eff = {1'b0, base} + {3'b000, idx};
    exp_err = 1'b0;
    exp_data = 32'd0;
    if (int'(eff) >= LVA_SIZE || op == 2'b11) begin
      exp_err = 1'b1; exp_lat = 1; exp_trig = 0;
    end else if (tmo) begin
      exp_err = 1'b1; exp_lat = 2 + TMO; exp_trig = 1;
    end else if (op == 2'b00) begin
      exp_data = ref_mem[eff]; exp_lat = LVA_D + 2; exp_trig = 1;
    end else if (op == 2'b01) begin
      exp_data = val; ref_mem[eff] = val; exp_lat = LVA_D + 2; exp_trig = 1;
    end else begin
      exp_data = ref_mem[eff] + {{24{cst[7]}}, cst};
      ref_mem[eff] = exp_data; exp_lat = 2 * LVA_D + 3; exp_trig = 2;
    end

    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op = op;
    bus.frame_base = base;
    bus.cmd_index = idx;
    bus.cmd_value = val;
    bus.cmd_const = cst;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;

    got_lat = 0; trig_seen = 0; addr_ok = 1'b1; write_ok = 1'b1;
    got_data = 32'hX; got_err = 1'bX;
    for (int k = 1; k <= 200 && got_lat == 0; k++) begin
      @(negedge clk);
      if (bus.lva_trigger) begin
        trig_seen++;
        if (bus.lva_addr !== eff[ADDR-1:0]) addr_ok = 1'b0;
        // read first for LOAD/INC, the trigger of STORE or INC's second is a write
        if (bus.lva_write !== ((op == 2'b01) || (trig_seen == 2))) write_ok = 1'b0;
      end
      if (bus.rsp_valid) begin
        got_lat = k;
        got_data = bus.rsp_data;
        got_err = bus.rsp_err;
        check("cmd_ready_low_in_resp", 32'(bus.cmd_ready), 32'd0);
      end
    end
    check("rsp_latency", 32'(got_lat), 32'(exp_lat));
    check("rsp_err", 32'(got_err), 32'(exp_err));
    check("rsp_data", got_data, exp_data);
    check("trigger_count", 32'(trig_seen), 32'(exp_trig));
    if (exp_trig > 0) begin
      check("lva_addr", 32'(addr_ok), 32'd1);
      check("lva_write_dir", 32'(write_ok), 32'd1);
    end
    @(negedge clk);
    check("rsp_valid_one_cycle", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready_after_resp", 32'(bus.cmd_ready), 32'd1);
    check("rsp_data_hold", bus.rsp_data, got_data);
  endtask

  initial begin : main
    logic [31:0] d;
    logic bad;
    for (int i = 0; i < LVA_SIZE; i++) ref_mem[i] = seed_word(i);
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_index = 8'd0;
    bus.cmd_value = 32'd0;
    bus.cmd_const = 8'd0;
    bus.frame_base = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Store then load through base 16 / index 3 (slot 19).
    run_cmd(2'b01, 10'd16, 8'd3, 32'hDEADBEEF, 8'd0, 1'b0, d);
    run_cmd(2'b00, 10'd16, 8'd3, 32'd0, 8'd0, 1'b0, d);
    check("load_deadbeef", d, 32'hDEADBEEF);

    // Increment by -2, then read back.
    run_cmd(2'b01, 10'd40, 8'd2, 32'h5, 8'd0, 1'b0, d);
    run_cmd(2'b10, 10'd40, 8'd2, 32'd0, 8'hFE, 1'b0, d);
    check("inc_minus2", d, 32'h3);
    run_cmd(2'b00, 10'd40, 8'd2, 32'd0, 8'd0, 1'b0, d);
    check("load_after_inc", d, 32'h3);

    // Increment wraps mod 2^32.
    run_cmd(2'b01, 10'd100, 8'd0, 32'hFFFFFFFF, 8'd0, 1'b0, d);
    run_cmd(2'b10, 10'd100, 8'd0, 32'd0, 8'h01, 1'b0, d);
    check("inc_wrap", d, 32'h0);

    // Bounds and reserved op.
    run_cmd(2'b00, 10'd1020, 8'd4, 32'd0, 8'd0, 1'b0, d);
    run_cmd(2'b11, 10'd1020, 8'd4, 32'd0, 8'd0, 1'b0, d);
    run_cmd(2'b11, 10'd0, 8'd0, 32'd0, 8'd0, 1'b0, d);
    run_cmd(2'b10, 10'd1023, 8'd255, 32'd0, 8'd1, 1'b0, d);
    run_cmd(2'b01, 10'd1016, 8'd7, 32'hCAFEF00D, 8'd0, 1'b0, d);
    run_cmd(2'b00, 10'd1016, 8'd7, 32'd0, 8'd0, 1'b0, d);
    check("load_last_slot", d, 32'hCAFEF00D);

    // Reset during RD_WAIT; a late done afterwards must be ignored.
    mute = 1'b1;
    @(negedge clk);
    bus.cmd_op = 2'b00; bus.frame_base = 10'd16; bus.cmd_index = 8'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("trigger_before_reset", 32'(bus.lva_trigger), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray_cnt++;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.lva_trigger) bad = 1'b1;
    end
    check("stray_done_ignored", 32'(bad), 32'd0);
    mute = 1'b0;
    run_cmd(2'b00, 10'd16, 8'd3, 32'd0, 8'd0, 1'b0, d);
    check("load_after_reset", d, 32'hDEADBEEF);

`ifdef LVA_TIMEOUT_EN
    mute = 1'b1;
    run_cmd(2'b10, 10'd40, 8'd2, 32'd0, 8'd1, 1'b1, d);
    mute = 1'b0;
`endif

    // Randomized commands against the reference.
    for (int n = 0; n < 40; n++) begin
      logic [ADDR-1:0] b;
      logic [7:0] ix;
      b = ($urandom_range(0, 3) == 0) ? ADDR'($urandom_range(768, 1023))
                                      : ADDR'($urandom_range(0, 63));
      ix = 8'($urandom_range(0, 255));
      run_cmd(2'($urandom_range(0, 3)), b, ix, $urandom, 8'($urandom), 1'b0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
